// File: rtl/decode_sb.sv
// RV32I decode stage: field extraction, register file and per-register write scoreboard (RAW interlock).
// Optional macro DECODE_BYPASS_EN forwards a same-cycle writeback into a dependent operand.
module decode_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int SB_W = 2,
  localparam int IW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [31:0]     f_instr,
  input  logic [XLEN-1:0] f_pc,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [31:0]     d_instr,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_rs1_dat,
  output logic [XLEN-1:0] d_rs2_dat,
  output logic [IW-1:0]   d_rd_ind,
  output logic            d_rd_wr,
  input  logic            wb_en,
  input  logic [IW-1:0]   wb_ind,
  input  logic [XLEN-1:0] wb_dat,
  input  logic            flush,
  output logic            hz_stall
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_OP  = 7'b0110011, OP_ST    = 7'b0100011, OP_BR  = 7'b1100011;
  localparam logic [SB_W-1:0] CNT_MAX = '1;
  localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);

  logic [XLEN-1:0] rf_q  [NREG];
  logic [XLEN-1:0] rf_d  [NREG];
  logic [SB_W-1:0] cnt_q [NREG];
  logic [SB_W-1:0] cnt_d [NREG];

  logic            d_valid_q, d_valid_d, d_rd_wr_q, d_rd_wr_d;
  logic [31:0]     d_instr_q, d_instr_d;
  logic [XLEN-1:0] d_pc_q, d_pc_d, d_rs1_q, d_rs1_d, d_rs2_q, d_rs2_d;
  logic [IW-1:0]   d_rd_q, d_rd_d;

  logic [6:0]      opc;
  logic [IW-1:0]   rs1, rs2, rd;
  logic            rs1_use, rs2_use, rd_wr, wb_hit, byp1, byp2, hz1, hz2, sat, hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opc = f_instr[6:0];
  assign rs1 = f_instr[15 +: IW];
  assign rs2 = f_instr[20 +: IW];
  assign rd  = f_instr[7 +: IW];

  always_comb begin
    rs1_use = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    rs2_use = (opc == OP_OP || opc == OP_ST || opc == OP_BR);
    rd_wr   = (rd != '0) && (opc != OP_ST) && (opc != OP_BR);
    wb_hit  = wb_en && (wb_ind != '0);
`ifdef DECODE_BYPASS_EN
    // Last outstanding write retiring this cycle: take its data instead of stalling.
    byp1 = wb_hit && (wb_ind == rs1) && (cnt_q[rs1] == CNT_ONE);
    byp2 = wb_hit && (wb_ind == rs2) && (cnt_q[rs2] == CNT_ONE);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    hz1      = rs1_use && (rs1 != '0) && (cnt_q[rs1] != '0) && !byp1;
    hz2      = rs2_use && (rs2 != '0) && (cnt_q[rs2] != '0) && !byp2;
    sat      = rd_wr && (cnt_q[rd] == CNT_MAX);
    hazard   = hz1 || hz2 || sat;
    f_ready  = (!d_valid_q || d_ready) && !hazard && !flush;
    hz_stall = f_valid && hazard;
    accept   = f_valid && f_ready;
    rs1_val  = (!rs1_use || rs1 == '0) ? '0 : (byp1 ? wb_dat : rf_q[rs1]);
    rs2_val  = (!rs2_use || rs2 == '0) ? '0 : (byp2 ? wb_dat : rf_q[rs2]);
  end

  always_comb begin
    d_valid_d = d_valid_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_rs1_d   = d_rs1_q;
    d_rs2_d   = d_rs2_q;
    d_rd_d    = d_rd_q;
    d_rd_wr_d = d_rd_wr_q;
    if (flush) begin
      d_valid_d = 1'b0;
    end else if (accept) begin
      d_valid_d = 1'b1;
      d_instr_d = f_instr;
      d_pc_d    = f_pc;
      d_rs1_d   = rs1_val;
      d_rs2_d   = rs2_val;
      d_rd_d    = rd;
      d_rd_wr_d = rd_wr;
    end else if (d_ready) begin
      d_valid_d = 1'b0;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_ind] = wb_dat;
    cnt_d = cnt_q;
    for (int i = 0; i < NREG; i++) begin
      // Issue and retire on the same register cancel out.
      if (flush)
        cnt_d[i] = '0;
      else if (accept && rd_wr && rd == IW'(i) && !(wb_hit && wb_ind == IW'(i)))
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (wb_hit && wb_ind == IW'(i) && !(accept && rd_wr && rd == IW'(i)) && cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_q <= 1'b0;
      d_instr_q <= '0;
      d_pc_q    <= '0;
      d_rs1_q   <= '0;
      d_rs2_q   <= '0;
      d_rd_q    <= '0;
      d_rd_wr_q <= 1'b0;
      rf_q      <= '{default: '0};
      cnt_q     <= '{default: '0};
    end else begin
      d_valid_q <= d_valid_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_rs1_q   <= d_rs1_d;
      d_rs2_q   <= d_rs2_d;
      d_rd_q    <= d_rd_d;
      d_rd_wr_q <= d_rd_wr_d;
      rf_q      <= rf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign d_valid   = d_valid_q;
  assign d_instr   = d_instr_q;
  assign d_pc      = d_pc_q;
  assign d_rs1_dat = d_rs1_q;
  assign d_rs2_dat = d_rs2_q;
  assign d_rd_ind  = d_rd_q;
  assign d_rd_wr   = d_rd_wr_q;
endmodule

// File: tb/tb_decode_sb.sv
// Randomized + directed bench for decode_sb against a cycle-level behavioural model.
module tb_decode_sb;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int SBMAX = 3;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011, ST = 7'b0100011, BR = 7'b1100011, LD = 7'b0000011;

  logic clk = 1'b0, rst = 1'b1;
  logic f_valid = 0, f_ready, d_valid, d_ready = 0, d_rd_wr, wb_en = 0, flush = 0, hz_stall;
  logic [31:0] f_instr = 0, f_pc = 0, d_instr, d_pc, d_rs1_dat, d_rs2_dat, wb_dat = 0;
  logic [4:0]  d_rd_ind, wb_ind = 0;

  decode_sb dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc),
    .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr), .d_pc(d_pc), .d_rs1_dat(d_rs1_dat),
    .d_rs2_dat(d_rs2_dat), .d_rd_ind(d_rd_ind), .d_rd_wr(d_rd_wr), .wb_en(wb_en), .wb_ind(wb_ind),
    .wb_dat(wb_dat), .flush(flush), .hz_stall(hz_stall));

  always #5 clk = ~clk;

  // Architectural model: register values, pending-write counts, output slot.
  logic [31:0] m_rf [32];
  int          m_cnt [32];
  logic        m_v, m_rdwr;
  logic [31:0] m_instr, m_pc, m_rs1, m_rs2;
  logic [4:0]  m_rd;
  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_cnt[i] = 0; end
    m_v = 0; m_rdwr = 0; m_instr = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int r1, input int r2,
                                     input logic [6:0] hi);
    logic [4:0] a, b, c;
    a = 5'(rd); b = 5'(r1); c = 5'(r2);
    return {hi, c, b, 3'b000, a, op};
  endfunction

  // One cycle: drive inputs, compare at negedge, advance model, return just after the next posedge.
  task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc, input logic dr,
                      input logic we, input logic [4:0] wi, input logic [31:0] wd, input logic fl,
                      output logic acc);
    logic [6:0] opc;
    int r1, r2, rd;
    logic u1, u2, wr, fw1, fw2, haz, frdy, inc, dec;
    logic [31:0] v1, v2;
    f_valid = fv; f_instr = ins; f_pc = pc; d_ready = dr; wb_en = we; wb_ind = wi; wb_dat = wd; flush = fl;
    @(negedge clk);
    opc = ins[6:0]; r1 = int'(ins[19:15]); r2 = int'(ins[24:20]); rd = int'(ins[11:7]);
    u1  = !(opc inside {LUI, AUIPC, JAL});
    u2  = opc inside {OPR, ST, BR};
    wr  = rd != 0 && !(opc inside {ST, BR});
    fw1 = BYP && we && int'(wi) == r1 && r1 != 0 && m_cnt[r1] == 1;
    fw2 = BYP && we && int'(wi) == r2 && r2 != 0 && m_cnt[r2] == 1;
    haz = (u1 && r1 != 0 && m_cnt[r1] != 0 && !fw1) || (u2 && r2 != 0 && m_cnt[r2] != 0 && !fw2) ||
          (wr && m_cnt[rd] == SBMAX);
    frdy = (!m_v || dr) && !haz && !fl;
    v1 = (!u1 || r1 == 0) ? 32'h0 : (fw1 ? wd : m_rf[r1]);
    v2 = (!u2 || r2 == 0) ? 32'h0 : (fw2 ? wd : m_rf[r2]);
    chk("f_ready", 32'(f_ready), 32'(frdy));
    chk("hz_stall", 32'(hz_stall), 32'(fv && haz));
    chk("d_valid", 32'(d_valid), 32'(m_v));
    chk("d_instr", d_instr, m_instr);
    chk("d_pc", d_pc, m_pc);
    chk("d_rs1_dat", d_rs1_dat, m_rs1);
    chk("d_rs2_dat", d_rs2_dat, m_rs2);
    chk("d_rd_ind", 32'(d_rd_ind), 32'(m_rd));
    chk("d_rd_wr", 32'(d_rd_wr), 32'(m_rdwr));
    acc = fv && frdy;
    if (fl) begin
      m_v = 0;
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      if (acc) begin
        m_v = 1; m_instr = ins; m_pc = pc; m_rs1 = v1; m_rs2 = v2; m_rd = 5'(rd); m_rdwr = wr;
      end else if (dr) m_v = 0;
      inc = acc && wr;
      dec = we && wi != 0;
      if (!(inc && dec && int'(wi) == rd)) begin
        if (dec && m_cnt[wi] > 0) m_cnt[wi]--;
        if (inc) m_cnt[rd]++;
      end
    end
    if (we && wi != 0) m_rf[wi] = wd;
    @(posedge clk);
    #1;
  endtask

  logic acc;
  logic [31:0] cur, ins_add, ins_x5, ins_x6;
  int n;

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_d_instr", d_instr, 0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    chk("rst_f_ready", 32'(f_ready), 1);

    // Stream of two independent addis.
    step(1, {12'd5, 5'd0, 3'b0, 5'd1, OPI}, 32'h100, 1, 0, 0, 0, 0, acc);
    step(1, {12'd7, 5'd0, 3'b0, 5'd2, OPI}, 32'h104, 1, 0, 0, 0, 0, acc);
    chk("t2_rd", 32'(d_rd_ind), 2);
    chk("t2_cnt1", m_cnt[1], 1);
    chk("t2_cnt2", m_cnt[2], 1);

    // RAW on x1/x2: retire x2 first, then x1 at cycle N.
    ins_add = mk(OPR, 3, 1, 2, 7'd0);
    step(1, ins_add, 32'h108, 1, 1, 5'd2, 32'd7, 0, acc);
    chk("t3_hz_stall", 32'(hz_stall), 1);
    chk("t3_f_ready", 32'(f_ready), 0);
    step(1, ins_add, 32'h108, 1, 1, 5'd1, 32'd5, 0, acc);
    chk("t3_acc_at_N", 32'(acc), 32'(BYP));
    n = 0;
    while (!acc && n < 3) begin
      step(1, ins_add, 32'h108, 1, 0, 0, 0, 0, acc);
      n++;
    end
    chk("t3_rs1", d_rs1_dat, 5);
    chk("t3_rs2", d_rs2_dat, 7);

    // Backpressure holds the slot.
    ins_x5 = {12'd1, 5'd0, 3'b0, 5'd5, OPI};
    ins_x6 = {12'd2, 5'd0, 3'b0, 5'd6, OPI};
    step(1, ins_x5, 32'h10c, 1, 0, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++) begin
      step(1, ins_x6, 32'h110, 0, 0, 0, 0, 0, acc);
      chk("t4_hold", d_instr, ins_x5);
      chk("t4_f_ready", 32'(f_ready), 0);
    end
    step(1, ins_x6, 32'h110, 1, 0, 0, 0, 0, acc);
    chk("t4_release", d_instr, ins_x6);

    // Saturation on x4.
    for (int i = 0; i < 4; i++) step(1, {12'd9, 5'd0, 3'b0, 5'd4, OPI}, 32'h200, 1, 0, 0, 0, 0, acc);
    chk("t5_hz_stall", 32'(hz_stall), 1);
    step(1, {12'd9, 5'd0, 3'b0, 5'd4, OPI}, 32'h200, 1, 1, 5'd4, 32'd44, 0, acc);
    step(1, {12'd9, 5'd0, 3'b0, 5'd4, OPI}, 32'h200, 1, 0, 0, 0, 0, acc);
    chk("t5_acc", 32'(acc), 1);
    chk("t5_cnt4", m_cnt[4], 3);

    // Flush with coincident writeback.
    step(1, {12'd1, 5'd0, 3'b0, 5'd1, OPI}, 32'h300, 1, 0, 0, 0, 0, acc);
    step(1, {12'd1, 5'd0, 3'b0, 5'd1, OPI}, 32'h304, 1, 0, 0, 0, 0, acc);
    chk("t6_pre_valid", 32'(d_valid), 1);
    step(0, 0, 0, 0, 1, 5'd1, 32'd9, 1, acc);
    chk("t6_valid", 32'(d_valid), 0);
    chk("t6_cnt1", m_cnt[1], 0);
    step(1, mk(OPR, 7, 1, 0, 7'd0), 32'h308, 1, 0, 0, 0, 0, acc);
    chk("t6_x1", d_rs1_dat, 9);

    // Random traffic.
    cur = 0; acc = 1;
    for (int c = 0; c < 2500; c++) begin
      logic [6:0] ops [8];
      ops = '{LUI, AUIPC, JAL, OPR, OPI, ST, BR, LD};
      if (acc) cur = mk(ops[$urandom_range(0, 7)], $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), 7'($urandom));
      step($urandom_range(0, 3) != 0, cur, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 63) == 0, acc);
    end

    // Asynchronous reset mid-stream.
    f_valid = 1; f_instr = mk(OPR, 3, 5, 0, 7'd0);
    rst = 1;
    #2;
    m_reset();
    chk("mrst_d_valid", 32'(d_valid), 0);
    chk("mrst_d_pc", d_pc, 0);
    chk("mrst_d_rs1", d_rs1_dat, 0);
    f_valid = 0; wb_en = 0; flush = 0;
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    chk("mrst_f_ready", 32'(f_ready), 1);
    step(1, {12'd1, 5'd0, 3'b0, 5'd5, OPI}, 32'h400, 1, 0, 0, 0, 0, acc);
    step(1, mk(OPR, 6, 5, 0, 7'd0), 32'h404, 1, 0, 0, 0, 0, acc);
    step(0, 0, 0, 1, 0, 0, 0, 0, acc);
    chk("mrst_x5", d_rs1_dat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
